// File: rtl/pn_pkg.sv
// pn_pkg -- shared definitions for the PN ROM read controller.
//   pn_state_t    : controller FSM states (IDLE / RUN / DRAIN)
//   PN_ADDR_WIDTH : default PN ROM address width
//   PN_SEQ_LEN    : default number of chips in one PN period
//   PN_TAG_W      : width of the per-read {sof,eof} tag
package pn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pn_state_t;

  localparam int PN_ADDR_WIDTH = 10;
  localparam int PN_SEQ_LEN    = 1023;
  localparam int PN_TAG_W      = 2;

endpackage

// File: rtl/pn_tag_pipe.sv
// pn_tag_pipe -- DEPTH-stage shift register that carries the {sof,eof} tag
// of each ROM read so it lines up with the data the ROM returns DEPTH
// clocks later. Shifts every clock; idle slots carry an all-zero tag.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, clears every stage
//   tag_in  : tag launched with the ROM read strobe
//   tag_out : tag aligned with the ROM's valid response
module pn_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tag_in,
  output logic [WIDTH-1:0] tag_out
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/pn_rom_ctrl.sv
// pn_rom_ctrl -- reads a PN sequence out of a ROM one chip every SPC clocks
// and presents it as a registered chip stream with sof/eof markers.
// Optional feature macro: PN_ROM_CTRL_LOOP_EN adds loop_cnt[7:0]; the run then
// ends by itself after loop_cnt+1 full periods instead of running until stop.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin a run (only looked at in IDLE, ignored if stop is high)
//   stop       : abort the run (looked at in RUN)
//   loop_cnt   : (PN_ROM_CTRL_LOOP_EN only) periods to play minus one
//   busy       : high in RUN or DRAIN
//   rom_ena    : one-cycle ROM read strobe
//   rom_addr   : ROM read address
//   rom_data   : ROM chip
//   rom_valid  : rom_data is valid
//   chip_out   : registered chip
//   chip_valid : chip_out is valid
//   sof / eof  : chip is address 0 / SEQ_LEN-1, qualified by chip_valid
//   state_dbg  : current FSM state (pn_state_t encoding)
//
// ROM contract: every cycle with rom_ena=1 is one read of rom_addr; the ROM
// answers exactly ROM_LAT clocks later with rom_valid=1 for one cycle. There
// is no back-pressure, and rom_valid is registered unconditionally, whatever
// state the controller is in.
module pn_rom_ctrl
  import pn_pkg::*;
#(
  parameter int ADDR_WIDTH = PN_ADDR_WIDTH,
  parameter int SEQ_LEN    = PN_SEQ_LEN,
  parameter int SPC        = 8,
  parameter int ROM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
`ifdef PN_ROM_CTRL_LOOP_EN
  input  logic [7:0]            loop_cnt,
`endif
  output logic                  busy,
  output logic                  rom_ena,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic                  rom_data,
  input  logic                  rom_valid,
  output logic                  chip_out,
  output logic                  chip_valid,
  output logic                  sof,
  output logic                  eof,
  output logic [1:0]            state_dbg
);

  localparam int                    CNT_W      = (SPC > 1) ? $clog2(SPC) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(SPC - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(SEQ_LEN - 1);
  localparam logic [1:0]            DRAIN_LAST = 2'(ROM_LAT - 1);

  pn_state_t               state, state_nxt;
  logic [CNT_W-1:0]        chip_cnt;
  logic [1:0]              drain_cnt;
  logic                    run_entry;
  logic [PN_TAG_W-1:0]     tag_in, tag_out;
`ifdef PN_ROM_CTRL_LOOP_EN
  logic [7:0]              loop_rem;
`endif

  // Next state and read strobe. stop wins over a read slot so an abort
  // never launches a read that DRAIN would not wait for.
  always_comb begin
    state_nxt = state;
    rom_ena   = 1'b0;
    run_entry = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          run_entry = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else begin
          rom_ena = (chip_cnt == '0);
`ifdef PN_ROM_CTRL_LOOP_EN
          // Issuing the last address of the last period ends the run.
          if (rom_ena && (rom_addr == ADDR_LAST) && (loop_rem == 8'd0))
            state_nxt = DRAIN;
`endif
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The register still holds the old state during reset; keep the
    // strobe quiet so no read escapes.
    if (rst) rom_ena = 1'b0;
  end

  assign busy      = !rst && (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      chip_cnt  <= '0;
      drain_cnt <= '0;
      rom_addr  <= '0;
`ifdef PN_ROM_CTRL_LOOP_EN
      loop_rem  <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
      if (run_entry) begin
        chip_cnt <= '0;
        rom_addr <= '0;
`ifdef PN_ROM_CTRL_LOOP_EN
        loop_rem <= loop_cnt;
`endif
      end else if (state == RUN) begin
        chip_cnt <= (chip_cnt == CNT_LAST) ? '0 : chip_cnt + 1'b1;
        if (rom_ena) begin
          rom_addr <= (rom_addr == ADDR_LAST) ? '0 : rom_addr + 1'b1;
`ifdef PN_ROM_CTRL_LOOP_EN
          if ((rom_addr == ADDR_LAST) && (loop_rem != 8'd0))
            loop_rem <= loop_rem - 8'd1;
`endif
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  // Tag = {sof, eof} of the address being read this cycle.
  assign tag_in = rom_ena ? {rom_addr == '0, rom_addr == ADDR_LAST} : '0;

  pn_tag_pipe #(
    .DEPTH (ROM_LAT),
    .WIDTH (PN_TAG_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      chip_out   <= 1'b0;
      chip_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
    end else begin
      chip_valid <= rom_valid;
      sof        <= rom_valid & tag_out[1];
      eof        <= rom_valid & tag_out[0];
      if (rom_valid) chip_out <= rom_data;
    end
  end

endmodule
